// File: rtl/regfile_pkg.sv
`default_nettype none
// ============================================================================
//  Module      : regfile_pkg
//  Description : Shared constants and types for the register-file write-back
//                buffer: address/data widths, the queued write entry and the
//                hardwired-zero register address.
//  Revision    : 1.0 - initial release
// ============================================================================
package regfile_pkg;

  localparam int ADDR_W = 6;
  localparam int DATA_W = 32;

  // One pending register write.
  typedef struct packed {
    logic [ADDR_W-1:0] wa;
    logic [DATA_W-1:0] wd;
  } wb_entry_t;

  // r0 reads as zero; writes to it are dropped.
  localparam logic [ADDR_W-1:0] REG_ZERO = '0;

endpackage
`default_nettype wire

// File: rtl/regfile_wb_buffer_if.sv
`default_nettype none
// ============================================================================
//  Module      : regfile_wb_buffer_if
//  Description : Bundle of the write-back buffer's bus signals.
//                master : execute/operand-read side (drives results, hold and
//                         read addresses; observes ready, write port, lookup)
//                slave  : the write-back buffer itself
//  Ports       : in_valid/in_ready/in_wa/in_wd  - result handshake
//                wb_hold                         - drain suppression
//                we/wa/wd                        - register file write port
//                ra1/ra2, hit1/hit2, fwd1/fwd2   - pending-write lookup
//                count                           - occupancy
//  Revision    : 1.0 - initial release
// ============================================================================
interface regfile_wb_buffer_if #(
  parameter int DEPTH  = 4,
  parameter int ADDR_W = regfile_pkg::ADDR_W,
  parameter int DATA_W = regfile_pkg::DATA_W
);

  localparam int CNT_W = $clog2(DEPTH) + 1;

  logic              in_valid;
  logic              in_ready;
  logic [ADDR_W-1:0] in_wa;
  logic [DATA_W-1:0] in_wd;
  logic              wb_hold;
  logic              we;
  logic [ADDR_W-1:0] wa;
  logic [DATA_W-1:0] wd;
  logic [ADDR_W-1:0] ra1;
  logic [ADDR_W-1:0] ra2;
  logic              hit1;
  logic              hit2;
  logic [DATA_W-1:0] fwd1;
  logic [DATA_W-1:0] fwd2;
  logic [CNT_W-1:0]  count;

  modport master (
    output in_valid, in_wa, in_wd, wb_hold, ra1, ra2,
    input  in_ready, we, wa, wd, hit1, hit2, fwd1, fwd2, count
  );

  modport slave (
    input  in_valid, in_wa, in_wd, wb_hold, ra1, ra2,
    output in_ready, we, wa, wd, hit1, hit2, fwd1, fwd2, count
  );

endinterface
`default_nettype wire

// File: rtl/regfile_wb_match.sv
`default_nettype none
// ============================================================================
//  Module      : regfile_wb_match
//  Description : Pending-write lookup for one read port. Scans the occupied
//                queue slots from oldest to newest so the newest match wins.
//                Address 0 never hits.
//  Config      : REGFILE_WB_FWD_EN - when defined, the matching data is
//                returned on data_o; otherwise only hit_o exists.
//  Ports       : head_i  - oldest entry index
//                count_i - number of occupied entries
//                wa_i    - stored destination addresses
//                wd_i    - stored data (forwarding build only)
//                ra_i    - read address to look up
//                hit_o   - some pending write targets ra_i
//                data_o  - newest pending data for ra_i (forwarding build)
//  Revision    : 1.0 - initial release
// ============================================================================
module regfile_wb_match #(
  parameter int DEPTH  = 4,
`ifdef REGFILE_WB_FWD_EN
  parameter int DATA_W = regfile_pkg::DATA_W,
`endif
  parameter int ADDR_W = regfile_pkg::ADDR_W
) (
  input  logic [$clog2(DEPTH)-1:0] head_i,
  input  logic [$clog2(DEPTH):0]   count_i,
  input  logic [ADDR_W-1:0]        wa_i [DEPTH],
`ifdef REGFILE_WB_FWD_EN
  input  logic [DATA_W-1:0]        wd_i [DEPTH],
  output logic [DATA_W-1:0]        data_o,
`endif
  input  logic [ADDR_W-1:0]        ra_i,
  output logic                     hit_o
);

  import regfile_pkg::*;

  localparam int PTR_W = $clog2(DEPTH);
  localparam int CNT_W = PTR_W + 1;

  // Slot i is the i-th oldest entry; pointer arithmetic wraps because DEPTH
  // is a power of two. Later iterations override earlier ones, giving
  // newest-wins priority.
  always_comb begin
    hit_o = 1'b0;
`ifdef REGFILE_WB_FWD_EN
    data_o = '0;
`endif
    for (int i = 0; i < DEPTH; i++) begin
      if ((CNT_W'(i) < count_i) && (ra_i != ADDR_W'(REG_ZERO)) &&
          (wa_i[head_i + PTR_W'(i)] == ra_i)) begin
        hit_o = 1'b1;
`ifdef REGFILE_WB_FWD_EN
        data_o = wd_i[head_i + PTR_W'(i)];
`endif
      end
    end
  end

endmodule
`default_nettype wire

// File: rtl/regfile_wb_buffer.sv
`default_nettype none
// ============================================================================
//  Module      : regfile_wb_buffer
//  Description : In-order write-back queue in front of the register file's
//                write port. Accepts results over valid/ready, commits at
//                most one write per cycle from registered head storage, and
//                offers a two-port pending-write lookup.
//  Config      : REGFILE_WB_FWD_EN - when defined, fwd1/fwd2 carry the newest
//                pending data; otherwise they are tied to zero.
//  Ports       : clk   - rising-edge clock
//                rst_n - synchronous active-low reset
//                bus   - regfile_wb_buffer_if.slave (handshake, write port,
//                        lookup, occupancy)
//  Revision    : 1.0 - initial release
// ============================================================================
module regfile_wb_buffer #(
  parameter int DEPTH  = 4,
  parameter int ADDR_W = regfile_pkg::ADDR_W,
  parameter int DATA_W = regfile_pkg::DATA_W
) (
  input  logic                clk,
  input  logic                rst_n,
  regfile_wb_buffer_if.slave  bus
);

  import regfile_pkg::*;

  localparam int               PTR_W    = $clog2(DEPTH);
  localparam int               CNT_W    = PTR_W + 1;
  localparam logic [CNT_W-1:0] FULL_CNT = CNT_W'(DEPTH);

  logic [ADDR_W-1:0] wa_q [DEPTH];
  logic [DATA_W-1:0] wd_q [DEPTH];

  logic [PTR_W-1:0]  head_q, head_d;
  logic [PTR_W-1:0]  tail_q, tail_d;
  logic [CNT_W-1:0]  count_q, count_d;
  logic              rdy_q;

  logic              accept;
  logic              store;
  logic              pop;

  always_comb begin
    accept  = bus.in_valid && rdy_q;
    // r0 writes complete the handshake but never occupy a slot.
    store   = accept && (bus.in_wa != ADDR_W'(REG_ZERO));
    pop     = (count_q != '0) && !bus.wb_hold;
    head_d  = pop   ? head_q + PTR_W'(1) : head_q;
    tail_d  = store ? tail_q + PTR_W'(1) : tail_q;
    count_d = count_q + CNT_W'(store) - CNT_W'(pop);
  end

  // Ready is registered from the next occupancy so it never depends
  // combinationally on in_valid or wb_hold, and it stays low for the cycle
  // following a reset edge.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      head_q  <= '0;
      tail_q  <= '0;
      count_q <= '0;
      rdy_q   <= 1'b0;
    end else begin
      head_q  <= head_d;
      tail_q  <= tail_d;
      count_q <= count_d;
      rdy_q   <= (count_d != FULL_CNT);
    end
  end

  // Storage needs no reset: occupancy alone defines which slots are live.
  always_ff @(posedge clk) begin
    if (store) begin
      wa_q[tail_q] <= bus.in_wa;
      wd_q[tail_q] <= bus.in_wd;
    end
  end

  assign bus.in_ready = rdy_q;
  assign bus.count    = count_q;
  assign bus.we       = pop;
  assign bus.wa       = pop ? wa_q[head_q] : '0;
  assign bus.wd       = pop ? wd_q[head_q] : '0;

`ifdef REGFILE_WB_FWD_EN
  regfile_wb_match #(
    .DEPTH  (DEPTH),
    .DATA_W (DATA_W),
    .ADDR_W (ADDR_W)
  ) u_match1 (
    .head_i  (head_q),
    .count_i (count_q),
    .wa_i    (wa_q),
    .wd_i    (wd_q),
    .data_o  (bus.fwd1),
    .ra_i    (bus.ra1),
    .hit_o   (bus.hit1)
  );

  regfile_wb_match #(
    .DEPTH  (DEPTH),
    .DATA_W (DATA_W),
    .ADDR_W (ADDR_W)
  ) u_match2 (
    .head_i  (head_q),
    .count_i (count_q),
    .wa_i    (wa_q),
    .wd_i    (wd_q),
    .data_o  (bus.fwd2),
    .ra_i    (bus.ra2),
    .hit_o   (bus.hit2)
  );
`else
  regfile_wb_match #(
    .DEPTH  (DEPTH),
    .ADDR_W (ADDR_W)
  ) u_match1 (
    .head_i  (head_q),
    .count_i (count_q),
    .wa_i    (wa_q),
    .ra_i    (bus.ra1),
    .hit_o   (bus.hit1)
  );

  regfile_wb_match #(
    .DEPTH  (DEPTH),
    .ADDR_W (ADDR_W)
  ) u_match2 (
    .head_i  (head_q),
    .count_i (count_q),
    .wa_i    (wa_q),
    .ra_i    (bus.ra2),
    .hit_o   (bus.hit2)
  );

  // Lookup still reports hits for stalling; no data path is built.
  assign bus.fwd1 = '0;
  assign bus.fwd2 = '0;
`endif

endmodule
`default_nettype wire

// File: tb/tb_regfile_wb_buffer.sv
`default_nettype none
// ============================================================================
//  Module      : tb_regfile_wb_buffer
//  Description : Self-checking bench for regfile_wb_buffer. A queue-based
//                reference model predicts ready, occupancy, write port and
//                lookup results every cycle for directed and random stimulus.
//  Config      : REGFILE_WB_FWD_EN - selects expected forwarding data.
//  Revision    : 1.0 - initial release
// ============================================================================
module tb_regfile_wb_buffer;

  import regfile_pkg::*;

  localparam int DEPTH = 4;

  logic clk   = 1'b0;
  logic rst_n = 1'b0;

  always #5 clk = ~clk;

  regfile_wb_buffer_if #(.DEPTH(DEPTH)) bus ();

  regfile_wb_buffer #(.DEPTH(DEPTH)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  int        total = 0;
  int        bad   = 0;
  wb_entry_t mq[$];          // pending writes, oldest first
  bit        after_rst = 1'b1;

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s @%0t: observed=%0h expected=%0h", tag, $time, obs, exp);
    end
  endtask

  // Newest pending write to ra, if any.
  function automatic void lookup(input logic [ADDR_W-1:0] ra, output logic hit,
                                 output logic [DATA_W-1:0] data);
    hit  = 1'b0;
    data = '0;
    if (ra != 0) begin
      foreach (mq[i]) begin
        if (mq[i].wa == ra) begin
          hit  = 1'b1;
          data = mq[i].wd;
        end
      end
    end
`ifndef REGFILE_WB_FWD_EN
    data = '0;
`endif
  endfunction

  // One clock cycle: drive at the falling edge, check mid-cycle, then advance
  // the model across the rising edge.
  task automatic step(input bit rn, input bit v, input logic [ADDR_W-1:0] a,
                      input logic [DATA_W-1:0] d, input bit hold,
                      input logic [ADDR_W-1:0] r1, input logic [ADDR_W-1:0] r2);
    logic              exp_rdy, exp_we, h1, h2;
    logic [DATA_W-1:0] f1, f2;
    wb_entry_t         e;
    @(negedge clk);
    rst_n        = rn;
    bus.in_valid = v;
    bus.in_wa    = a;
    bus.in_wd    = d;
    bus.wb_hold  = hold;
    bus.ra1      = r1;
    bus.ra2      = r2;
    #1;
    exp_rdy = !after_rst && (mq.size() < DEPTH);
    exp_we  = (mq.size() > 0) && !hold;
    check("in_ready", bus.in_ready, exp_rdy);
    check("count",    bus.count,    mq.size());
    check("we",       bus.we,       exp_we);
    check("wa",       bus.wa,       exp_we ? mq[0].wa : '0);
    check("wd",       bus.wd,       exp_we ? mq[0].wd : '0);
    lookup(r1, h1, f1);
    lookup(r2, h2, f2);
    check("hit1", bus.hit1, h1);
    check("fwd1", bus.fwd1, f1);
    check("hit2", bus.hit2, h2);
    check("fwd2", bus.fwd2, f2);
    @(posedge clk);
    if (!rn) begin
      mq.delete();
      after_rst = 1'b1;
    end else begin
      if (exp_we) void'(mq.pop_front());
      if (v && exp_rdy && a != 0) begin
        e.wa = a;
        e.wd = d;
        mq.push_back(e);
      end
      after_rst = 1'b0;
    end
  endtask

  initial begin
    bus.in_valid = 1'b0;
    bus.in_wa    = '0;
    bus.in_wd    = '0;
    bus.wb_hold  = 1'b0;
    bus.ra1      = '0;
    bus.ra2      = '0;
    repeat (2) @(posedge clk);

    // Reset state, then release.
    step(0, 0, 0, 0, 0, 5, 7);
    step(1, 0, 0, 0, 0, 5, 7);

    // Single push, written the next cycle, then empty.
    step(1, 1, 5, 32'hDEADBEEF, 0, 5, 0);
    step(1, 0, 0, 0, 0, 5, 0);
    step(1, 0, 0, 0, 0, 5, 0);

    // Fill under hold, fifth push refused, then drain in order.
    for (int i = 1; i <= 4; i++) step(1, 1, 6'(i), 32'h100 + 32'(i), 1, 6'(i), 3);
    step(1, 1, 9, 32'h999, 1, 9, 4);
    for (int i = 0; i < 5; i++) step(1, 0, 0, 0, 0, 2, 9);

    // Two writes to r7: newest wins; r0 never hits.
    step(1, 1, 7, 32'h11, 1, 7, 0);
    step(1, 1, 7, 32'h22, 1, 7, 0);
    step(1, 0, 0, 0, 1, 7, 0);
    for (int i = 0; i < 3; i++) step(1, 0, 0, 0, 0, 7, 0);

    // Write to r0 is accepted and dropped.
    step(1, 1, 0, 32'hFFFFFFFF, 0, 0, 0);
    step(1, 0, 0, 0, 0, 0, 0);
    step(1, 0, 0, 0, 0, 0, 0);

    // Sustained push+pop across pointer wrap.
    step(1, 1, 10, 32'hA000, 0, 10, 11);
    for (int i = 0; i < 20; i++)
      step(1, 1, 6'(11 + i), 32'hA001 + 32'(i), 0, 6'(11 + i), 6'(10 + i));
    step(1, 0, 0, 0, 0, 0, 0);
    step(1, 0, 0, 0, 0, 0, 0);

    // Reset mid-operation discards queued entries.
    for (int i = 0; i < 3; i++) step(1, 1, 6'(20 + i), 32'hC0 + 32'(i), 1, 20, 22);
    step(0, 0, 0, 0, 1, 20, 22);
    step(1, 0, 0, 0, 0, 20, 22);
    for (int i = 0; i < 3; i++) step(1, 0, 0, 0, 0, 21, 22);

    // Random traffic with occasional reset.
    for (int i = 0; i < 300; i++)
      step(($urandom_range(0, 99) != 0), $urandom_range(0, 1),
           6'($urandom_range(0, 7)), $urandom, ($urandom_range(0, 3) == 0),
           6'($urandom_range(0, 7)), 6'($urandom_range(0, 7)));

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
`default_nettype wire
